// File: rtl/rx_pkt_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkt_checker_if
// Purpose  : Bundles the ingress stream, the egress stream and the per-packet
//            result record of rx_pkt_checker.
// Ports    : in_valid/in_data/in_ready    - upstream word handshake
//            out_valid/out_data/out_ready - downstream word handshake
//            out_first/out_last           - header / final-word markers
//            res_valid/res_code/res_src/res_len - one-cycle result record
//            slave  modport : the checker
//            master modport : the environment driving and observing it
// Revision : 1.0 - initial release
// ============================================================================
interface rx_pkt_checker_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_first;
   logic        out_last;
   logic        out_ready;
   logic        res_valid;
   logic [1:0]  res_code;
   logic [7:0]  res_src;
   logic [7:0]  res_len;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_first, out_last,
             res_valid, res_code, res_src, res_len
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_first, out_last,
             res_valid, res_code, res_src, res_len
   );
endinterface
`default_nettype wire

// File: rtl/rx_pkt_checker.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkt_checker
// Purpose  : Ingress packet parser/filter. Each packet is a header word, LEN
//            payload words and a checksum word. Header and payload are passed
//            through with zero latency; misrouted or over-long packets are
//            swallowed. A one-cycle result record reports OK / CHECKSUM /
//            LENGTH / DEST for every completed packet.
// Ports    : clk    - clock
//            n_rst  - asynchronous active-low reset
//            abort  - synchronous flush of the in-flight packet
//            bus    - rx_pkt_checker_if.slave (in/out streams, result record)
//            busy   - high whenever a packet is in flight
// Revision : 1.0 - initial release
// ============================================================================
module rx_pkt_checker #(
   parameter logic [7:0]  NODE_ID = 8'd1,
   parameter int unsigned MAX_LEN = 128
) (
   input  wire logic          clk,
   input  wire logic          n_rst,
   input  wire logic          abort,
   rx_pkt_checker_if.slave    bus,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_DROP    = 2'd2,
      S_CHECK   = 2'd3
   } state_t;

   localparam logic [7:0] C_MAX_LEN  = 8'(MAX_LEN);
   localparam logic [1:0] C_RES_OK   = 2'd0;
   localparam logic [1:0] C_RES_CSUM = 2'd1;
   localparam logic [1:0] C_RES_LEN  = 2'd2;
   localparam logic [1:0] C_RES_DEST = 2'd3;

   state_t      r_state;
   logic [31:0] r_sum;
   logic [7:0]  r_rem;
   logic        r_drop;      // packet in flight was misrouted
   logic [7:0]  r_pkt_src;   // header fields of the packet in flight
   logic [7:0]  r_pkt_len;
   logic        r_res_valid;
   logic [1:0]  r_res_code;
   logic [7:0]  r_res_src;
   logic [7:0]  r_res_len;

   logic [7:0]  w_hdr_len;
   logic [7:0]  w_hdr_src;
   logic        w_len_err;
   logic        w_dest_err;
   logic        w_fwd;
   logic        w_in_ready;
   logic        w_last;
   logic        w_accept;
   logic [31:0] w_sum_next;

   assign w_hdr_len  = bus.in_data[7:0];
   assign w_hdr_src  = bus.in_data[31:24];
   assign w_len_err  = (w_hdr_len > C_MAX_LEN);
   assign w_dest_err = (bus.in_data[23:16] != NODE_ID);
   assign w_sum_next = r_sum + bus.in_data;

   // Decide per state whether the presented word is forwarded and whether it
   // can be taken. Swallowed words never wait on the downstream side.
   always_comb begin
      w_fwd      = 1'b0;
      w_in_ready = 1'b0;
      w_last     = 1'b0;
      if (!abort) begin
         case (r_state)
            S_IDLE: begin
               if (w_len_err || w_dest_err) begin
                  w_in_ready = 1'b1;
               end else begin
                  w_fwd      = 1'b1;
                  w_in_ready = bus.out_ready;
                  w_last     = (w_hdr_len == 8'd0);
               end
            end
            S_PAYLOAD: begin
               w_fwd      = 1'b1;
               w_in_ready = bus.out_ready;
               w_last     = (r_rem == 8'd1);
            end
            default: w_in_ready = 1'b1;   // S_DROP, S_CHECK
         endcase
      end
   end

   assign w_accept = bus.in_valid && w_in_ready;

   // Pass-through egress; reset masks out_valid so nothing leaks downstream.
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = n_rst && w_fwd && bus.in_valid;
   assign bus.out_data  = bus.in_data;
   assign bus.out_first = w_fwd && (r_state == S_IDLE);
   assign bus.out_last  = w_fwd && w_last;

   assign bus.res_valid = r_res_valid;
   assign bus.res_code  = r_res_code;
   assign bus.res_src   = r_res_src;
   assign bus.res_len   = r_res_len;
   assign busy          = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_sum       <= 32'd0;
         r_rem       <= 8'd0;
         r_drop      <= 1'b0;
         r_pkt_src   <= 8'd0;
         r_pkt_len   <= 8'd0;
         r_res_valid <= 1'b0;
         r_res_code  <= 2'd0;
         r_res_src   <= 8'd0;
         r_res_len   <= 8'd0;
      end else begin
         r_res_valid <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            r_sum   <= 32'd0;
            r_rem   <= 8'd0;
            r_drop  <= 1'b0;
         end else if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (w_len_err) begin
                     // Over-long header: report immediately, no packet body.
                     r_res_valid <= 1'b1;
                     r_res_code  <= C_RES_LEN;
                     r_res_src   <= w_hdr_src;
                     r_res_len   <= w_hdr_len;
                  end else begin
                     r_sum     <= bus.in_data;
                     r_rem     <= w_hdr_len;
                     r_drop    <= w_dest_err;
                     r_pkt_src <= w_hdr_src;
                     r_pkt_len <= w_hdr_len;
                     if (w_hdr_len == 8'd0)
                        r_state <= S_CHECK;
                     else if (w_dest_err)
                        r_state <= S_DROP;
                     else
                        r_state <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD, S_DROP: begin
                  r_sum <= w_sum_next;
                  r_rem <= r_rem - 8'd1;
                  if (r_rem == 8'd1)
                     r_state <= S_CHECK;
               end
               default: begin   // S_CHECK: word is the checksum
                  r_res_valid <= 1'b1;
                  r_res_src   <= r_pkt_src;
                  r_res_len   <= r_pkt_len;
                  if (r_drop)
                     r_res_code <= C_RES_DEST;
                  else if (bus.in_data == r_sum)
                     r_res_code <= C_RES_OK;
                  else
                     r_res_code <= C_RES_CSUM;
                  r_sum   <= 32'd0;
                  r_drop  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/rx_pkt_checker.md
Name: rx_pkt_checker

Overview:
- Ingress stage that sits between the switch egress port and the endpoint receive FSM / RX cache.
- Parses each incoming packet: one header word, LEN payload words, one trailing checksum word.
- Forwards header and payload downstream with a valid/ready handshake, and filters misrouted or malformed packets.
- Validates the checksum and emits a one-cycle result record (source ID, length, status) that the receive FSM uses for its requestor FIFO push.

Parameters:
- NODE_ID, 1, this endpoint's node ID (8 bits); a header dest field that differs from it marks the packet as misrouted.
- MAX_LEN, 128, maximum legal payload length in words (1..255).

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- abort  input  1  synchronous flush of the in-flight packet
- in_valid  input  1  upstream word valid
- in_data  input  32  upstream word
- in_ready  output  1  word accepted when in_valid && in_ready
- out_valid  output  1  downstream word valid
- out_data  output  32  downstream word (header or payload)
- out_first  output  1  out_data is a header
- out_last  output  1  out_data is the final forwarded word of the packet
- out_ready  input  1  downstream accepts
- res_valid  output  1  one-cycle result pulse
- res_code  output  2  0=OK, 1=CHECKSUM, 2=LENGTH, 3=DEST
- res_src  output  8  header source ID
- res_len  output  8  header length field
- busy  output  1  state != IDLE

Behaviour:
- Reset and interface decision: reset is n_rst, asynchronous, active-low; clock is clk.
  - Reset state is IDLE; sum, remaining count and result registers are 0.
  - res_valid=0, res_code=0, res_src=0, res_len=0, busy=0.
  - out_valid is 0 in reset; in_ready follows the comb rules below.
- Header format: [31:24] src, [23:16] dest, [15:8] reserved (forwarded unchanged), [7:0] LEN.
- Checksum: 32-bit sum mod 2^32 of the header and all payload words, including dropped packets. Carries are discarded.
- Forwarding is combinational pass-through (zero latency):
  - out_valid = in_valid, out_data = in_data when a word is being forwarded.
  - in_ready = out_ready in forwarding states; in_ready = 1 in DROP and CHECK.
- States:
  - IDLE: word at in_data is a header.
    - LEN > MAX_LEN: consume without forwarding, out_valid=0. Schedule res code 2; stay IDLE.
    - Else dest != NODE_ID: consume without forwarding. sum <= header; rem <= LEN; go to DROP (or CHECK if LEN=0).
    - Else: forward with out_first=1, out_last=(LEN==0). sum <= header; rem <= LEN; go to PAYLOAD (or CHECK if LEN=0).
  - PAYLOAD: forward each accepted word; sum += word; rem -= 1. out_last=1 when rem==1; rem reaching 0 goes to CHECK.
  - DROP: consume without forwarding; sum += word; rem -= 1; go to CHECK at 0. The DEST status is remembered.
  - CHECK: accepted word is the checksum and is never forwarded.
    - Status is 3 if the packet was dropped; else 0 if word == sum; else 1.
    - Go to IDLE.
- Result timing:
  - res_valid is registered: high exactly one cycle after the checksum handshake, or one cycle after a LENGTH header.
  - res_src/res_len are held until the next result.
  - A header accepted in the same cycle that res_valid is high is legal (back-to-back packets, no bubble).
- Stalls: with in_valid=0 or out_ready=0, nothing changes. Length LEN=0 is legal.
- abort:
  - Returns to IDLE and clears sum/rem; no result is produced.
  - A word presented the same cycle is not consumed (in_ready=0 while abort=1).
  - abort overrides a pending res_valid being set that cycle.
- Reset mid-packet: immediate return to IDLE; the partial packet is discarded with no result.
- Width: rem is 8 bits and never wraps, since LEN ≤ 255.

Test Plan:
- NODE_ID=1: header 0x0A010002, payload 0x10, 0x20, checksum 0x0A010032, out_ready=1 → 3 words forwarded (first on header, last on 0x20). res_valid one cycle after the checksum with code 0, src 0x0A, len 2.
- Same packet with checksum 0x0A010033 → payload forwarded; res code 1.
- Header 0x0A0100FF with MAX_LEN=128 → header consumed, nothing forwarded, res code 2 next cycle, busy stays 0. The next header is parsed normally.
- Header 0x0A050001, payload 0x1, checksum 0x0A050002 → no out_valid at any point, in_ready=1 throughout, res code 3.
- Backpressure: out_ready toggling 1,0,0,1 during the 2-word payload → in_ready tracks out_ready, no word is lost or duplicated, sum is still correct (code 0). Back-to-back second packet header accepted in the res_valid cycle.
- abort asserted after the first payload word → no res_valid, busy=0 the next cycle. A new packet with header 0x02010000 and checksum 0x02010000 → out_first=out_last=1 on the header, code 0.
